// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared constants, state encoding and skew helper for the 4x4
// output-stationary systolic array sequencer.
//   N  : array dimension (rows = columns)
//   DW : operand width
//   CW : accumulator width inside the array
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // Lane `lane` carries buffer entry (t - lane) at schedule step t when
    // that entry lies inside 0..k-1; outside that window the lane is 0.
    function automatic logic skew_valid(input int unsigned t,
                                        input int unsigned lane,
                                        input int unsigned k);
        return (t >= lane) && ((t - lane) < k);
    endfunction

endpackage

// File: rtl/systolic_mm_ctrl_skew_feeder.sv
// -----------------------------------------------------------------------------
// skew_feeder
// One edge lane of the systolic array: a K-deep operand buffer plus the
// registered, lane-skewed read that drives the array edge.
//   clk, rst : clock, asynchronous active-low reset (clears o_q only)
//   i_we     : buffer write strobe (already qualified by the controller)
//   i_wk     : buffer index to write
//   i_wd     : write data
//   i_lane   : lane offset (row i for A lanes, column j for B lanes)
//   i_en     : next cycle is a FEED/DRAIN cycle
//   i_t      : schedule step of the next cycle
//   o_q      : registered operand for the array edge
// -----------------------------------------------------------------------------
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int K  = 4,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [KW-1:0] i_wk,
    input  logic [DW-1:0] i_wd,
    input  logic [1:0]    i_lane,
    input  logic          i_en,
    input  logic [KW+2:0] i_t,
    output logic [DW-1:0] o_q
);

    // Indexed by the full k range so any wr_k value addresses an entry;
    // entries at K and above are never written (filtered upstream) nor read.
    logic [DW-1:0] r_buf [2**KW];
    logic [DW-1:0] r_q;
    logic [KW-1:0] w_off;
    logic          w_hit;

    always_comb begin
        // Only the low KW bits matter: when w_hit is set, t - lane < K <= 2**KW.
        w_off = i_t[KW-1:0] - KW'(i_lane);
        w_hit = i_en && skew_valid(32'(i_t), 32'(i_lane), K);
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_buf[i_wk] <= i_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_hit ? r_buf[w_off] : '0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/systolic_mm_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_mm_ctrl
// Sequencer for the 4x4 output-stationary systolic array. Buffers a 4xK A
// matrix and a Kx4 B matrix from the host, then per run: clears the array,
// streams skewed operands into its edges, waits for the wavefront to drain,
// and pulses done while c0..c15 hold A*B.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begin a run (honoured in IDLE or DONE only)
//   wr_en/sel/idx/k : operand buffer write (sel 0 = A[idx][k], 1 = B[k][idx])
//   wr_data         : operand value
//   arr_rst         : synchronous active-high reset for the array
//   in_a0..in_a3    : row feeds
//   in_b0..in_b3    : column feeds
//   busy            : high in CLEAR, FEED and DRAIN
//   done            : one-cycle pulse, results valid in that cycle
//   t_cnt           : schedule step (debug), 0 outside FEED/DRAIN
// -----------------------------------------------------------------------------
module systolic_mm_ctrl
    import systolic_pkg::*;
#(
    parameter int K  = 4,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [1:0]    wr_idx,
    input  logic [KW-1:0] wr_k,
    input  logic [DW-1:0] wr_data,
    output logic          arr_rst,
    output logic [DW-1:0] in_a0,
    output logic [DW-1:0] in_a1,
    output logic [DW-1:0] in_a2,
    output logic [DW-1:0] in_a3,
    output logic [DW-1:0] in_b0,
    output logic [DW-1:0] in_b1,
    output logic [DW-1:0] in_b2,
    output logic [DW-1:0] in_b3,
    output logic          busy,
    output logic          done,
    output logic [KW+2:0] t_cnt
);

    localparam logic [KW+2:0] T_FEED_LAST  = (KW+3)'(K + N - 2);
    localparam logic [KW+2:0] T_DRAIN_LAST = (KW+3)'(K + 2*N - 2);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW+2:0] r_t;
    logic [KW+2:0] w_t_nxt;
    logic          w_feed_nxt;
    logic          w_wr_ok;
    logic [DW-1:0] w_a [N];
    logic [DW-1:0] w_b [N];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = FEED;
            FEED:    if (r_t == T_FEED_LAST) w_state_nxt = DRAIN;
            DRAIN:   if (r_t == T_DRAIN_LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? CLEAR : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        arr_rst = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (r_state)
            IDLE:        arr_rst = 1'b1;
            CLEAR: begin
                arr_rst = 1'b1;
                busy    = 1'b1;
            end
            FEED, DRAIN: busy = 1'b1;
            DONE:        done = 1'b1;
            default:     arr_rst = 1'b1;
        endcase
    end

    // Feeders register their outputs, so they are driven from the schedule
    // step of the *next* cycle; this keeps in_a*/in_b* aligned with t_cnt.
    always_comb begin
        w_feed_nxt = (w_state_nxt == FEED) || (w_state_nxt == DRAIN);
        w_t_nxt    = '0;
        if (w_feed_nxt && (r_state != CLEAR)) begin
            w_t_nxt = r_t + (KW+3)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t <= '0;
        end else begin
            r_t <= w_t_nxt;
        end
    end

    always_comb begin
        w_wr_ok = wr_en && ((r_state == IDLE) || (r_state == DONE))
                  && (32'(wr_k) < K);
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_feeder #(
            .K  (K),
            .KW (KW)
        ) u_feed_a (
            .clk    (clk),
            .rst    (rst),
            .i_we   (w_wr_ok && !wr_sel && (wr_idx == 2'(g))),
            .i_wk   (wr_k),
            .i_wd   (wr_data),
            .i_lane (2'(g)),
            .i_en   (w_feed_nxt),
            .i_t    (w_t_nxt),
            .o_q    (w_a[g])
        );

        skew_feeder #(
            .K  (K),
            .KW (KW)
        ) u_feed_b (
            .clk    (clk),
            .rst    (rst),
            .i_we   (w_wr_ok && wr_sel && (wr_idx == 2'(g))),
            .i_wk   (wr_k),
            .i_wd   (wr_data),
            .i_lane (2'(g)),
            .i_en   (w_feed_nxt),
            .i_t    (w_t_nxt),
            .o_q    (w_b[g])
        );
    end

    assign in_a0 = w_a[0];
    assign in_a1 = w_a[1];
    assign in_a2 = w_a[2];
    assign in_a3 = w_a[3];
    assign in_b0 = w_b[0];
    assign in_b1 = w_b[1];
    assign in_b2 = w_b[2];
    assign in_b3 = w_b[3];
    assign t_cnt = r_t;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_mm_ctrl
// Drives systolic_mm_ctrl into a behavioural 4x4 output-stationary PE array
// and checks schedule, handshake and products against a reference multiply.
// -----------------------------------------------------------------------------
module tb_systolic_mm_ctrl;

    localparam int K  = 4;
    localparam int KW = 4;
    localparam int N  = 4;
    localparam int MAXC = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          wr_en;
    logic          wr_sel;
    logic [1:0]    wr_idx;
    logic [KW-1:0] wr_k;
    logic [15:0]   wr_data;
    logic          arr_rst;
    logic [15:0]   in_a0, in_a1, in_a2, in_a3;
    logic [15:0]   in_b0, in_b1, in_b2, in_b3;
    logic          busy;
    logic          done;
    logic [KW+2:0] t_cnt;

    always #5 clk = ~clk;

    systolic_mm_ctrl #(
        .K  (K),
        .KW (KW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_k    (wr_k),
        .wr_data (wr_data),
        .arr_rst (arr_rst),
        .in_a0   (in_a0),
        .in_a1   (in_a1),
        .in_a2   (in_a2),
        .in_a3   (in_a3),
        .in_b0   (in_b0),
        .in_b1   (in_b1),
        .in_b2   (in_b2),
        .in_b3   (in_b3),
        .busy    (busy),
        .done    (done),
        .t_cnt   (t_cnt)
    );

    // ---------------- behavioural PE array ----------------
    logic [15:0] a_in [4];
    logic [15:0] b_in [4];
    assign a_in[0] = in_a0;
    assign a_in[1] = in_a1;
    assign a_in[2] = in_a2;
    assign a_in[3] = in_a3;
    assign b_in[0] = in_b0;
    assign b_in[1] = in_b1;
    assign b_in[2] = in_b2;
    assign b_in[3] = in_b3;

    logic [15:0] pa  [4][4];
    logic [15:0] pb  [4][4];
    logic [31:0] acc [4][4];

    function automatic logic [15:0] a_at(input int i, input int j);
        if (j == 0) return a_in[i];
        return pa[i][j-1];
    endfunction

    function automatic logic [15:0] b_at(input int i, input int j);
        if (i == 0) return b_in[j];
        return pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (arr_rst) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= a_at(i, j);
                    pb[i][j]  <= b_at(i, j);
                    acc[i][j] <= acc[i][j] + 32'(a_at(i, j)) * 32'(b_at(i, j));
                end
            end
        end
    end

    // ---------------- bench state ----------------
    int errors = 0;
    int checks = 0;

    logic [15:0] ma [4][4];   // A[i][k]
    logic [15:0] mb [4][4];   // B[k][j]
    logic [31:0] sb [$];      // expected c0..c15 per run

    logic [15:0]   obs_a    [MAXC+1][4];
    logic [15:0]   obs_b    [MAXC+1][4];
    logic          obs_busy [MAXC+1];
    logic          obs_arr  [MAXC+1];
    logic [KW+2:0] obs_t    [MAXC+1];
    logic [31:0]   cap      [16];
    int            lat;

    task automatic wr(input logic sel, input int idx, input int k, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_idx  = 2'(idx);
        wr_k    = KW'(k);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load_mats();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < K; k++)
                wr(1'b0, i, k, ma[i][k]);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < 4; j++)
                wr(1'b1, j, k, mb[k][j]);
    endtask

    // Pushes the reference product, launches a run and records what the DUT
    // does each cycle until done (or the cycle budget runs out, lat = -1).
    task automatic do_run(input int start_at_t, input int wr_at_t, input bit hold);
        logic [31:0] s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int k = 0; k < K; k++) s = s + 32'(ma[i][k]) * 32'(mb[k][j]);
                sb.push_back(s);
            end
        end
        for (int c = 0; c < 16; c++) cap[c] = 'x;
        lat = -1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n <= MAXC; n++) begin
            if (n > 1) @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            obs_busy[n] = busy;
            obs_arr[n]  = arr_rst;
            obs_t[n]    = t_cnt;
            for (int l = 0; l < 4; l++) begin
                obs_a[n][l] = a_in[l];
                obs_b[n][l] = b_in[l];
            end
            if (done) begin
                lat = n;
                for (int c = 0; c < 16; c++) cap[c] = acc[c/4][c%4];
                if (hold) start = 1'b1;
                break;
            end
            if (busy && int'(t_cnt) == start_at_t) start = 1'b1;
            if (busy && int'(t_cnt) == wr_at_t) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_idx  = 2'd0;
                wr_k    = '0;
                wr_data = 16'd7;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic check_results(input string tag);
        logic [31:0] e;
        for (int c = 0; c < 16; c++) begin
            e = sb.pop_front();
            checks++;
            if (cap[c] !== e) begin
                errors++;
                $display("FAIL %s c%0d: got %h expected %h", tag, c, cap[c], e);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
        wr_idx = '0; wr_k = '0; wr_data = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({arr_rst, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 100", {arr_rst, busy, done});
        end
        checks++;
        if ({in_a0, in_a1, in_a2, in_a3, in_b0, in_b1, in_b2, in_b3} !== '0) begin
            errors++;
            $display("FAIL reset_ops: got %h expected 0",
                     {in_a0, in_a1, in_a2, in_a3, in_b0, in_b1, in_b2, in_b3});
        end
        checks++;
        if (t_cnt !== '0) begin
            errors++;
            $display("FAIL reset_tcnt: got %0d expected 0", t_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({arr_rst, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL idle_ctl: got %b expected 100", {arr_rst, busy, done});
        end
    endtask

    task automatic test_identity();
        int t;
        logic [15:0] e;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (i == k) ? 16'd1 : 16'd0;
                mb[k][i] = 16'(4*k + i + 1);
            end
        load_mats();
        do_run(-1, -1, 1'b0);
        checks++;
        if (lat !== K + 2*N + 1) begin
            errors++;
            $display("FAIL ident_latency: got %0d expected %0d", lat, K + 2*N + 1);
        end
        checks++;
        if (obs_a[4][1] !== 16'd1) begin
            errors++;
            $display("FAIL ident_a1_t2: got %h expected 0001", obs_a[4][1]);
        end
        for (int n = 1; n <= lat; n++) begin
            t = n - 2;
            if (n >= 2 && n < lat) begin
                checks++;
                if (int'(obs_t[n]) != t) begin
                    errors++;
                    $display("FAIL ident_tcnt n=%0d: got %0d expected %0d", n, obs_t[n], t);
                end
            end
            for (int l = 0; l < 4; l++) begin
                e = '0;
                if (n >= 2 && n < lat && t >= l && t - l < K) e = ma[l][t-l];
                checks++;
                if (obs_a[n][l] !== e) begin
                    errors++;
                    $display("FAIL ident_in_a%0d t=%0d: got %h expected %h", l, t, obs_a[n][l], e);
                end
                e = '0;
                if (n >= 2 && n < lat && t >= l && t - l < K) e = mb[t-l][l];
                checks++;
                if (obs_b[n][l] !== e) begin
                    errors++;
                    $display("FAIL ident_in_b%0d t=%0d: got %h expected %h", l, t, obs_b[n][l], e);
                end
            end
        end
        checks++;
        if (cap[5] !== 32'd6 || cap[15] !== 32'd16) begin
            errors++;
            $display("FAIL ident_c5_c15: got %0d,%0d expected 6,16", cap[5], cap[15]);
        end
        check_results("ident");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ident_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_ones();
        int nb;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'd1;
                mb[k][i] = 16'd1;
            end
        load_mats();
        do_run(-1, -1, 1'b0);
        nb = 0;
        for (int n = 1; n <= lat; n++) begin
            if (obs_busy[n] === 1'b1) nb++;
            checks++;
            if (obs_arr[n] !== (n == 1)) begin
                errors++;
                $display("FAIL ones_arr_rst n=%0d: got %b expected %b", n, obs_arr[n], (n == 1));
            end
        end
        checks++;
        if (nb !== K + 2*N) begin
            errors++;
            $display("FAIL ones_busy_cycles: got %0d expected %0d", nb, K + 2*N);
        end
        checks++;
        if (cap[0] !== 32'd4) begin
            errors++;
            $display("FAIL ones_c0: got %0d expected 4", cap[0]);
        end
        check_results("ones");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'hFFFF;
                mb[k][i] = 16'hFFFF;
            end
        load_mats();
        do_run(-1, -1, 1'b0);
        checks++;
        if (cap[10] !== 32'hFFF80004) begin
            errors++;
            $display("FAIL wrap_c10: got %h expected fff80004", cap[10]);
        end
        check_results("wrap");
    endtask

    task automatic test_abort();
        bit hit;
        int nd;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'($urandom_range(0, 65535));
                mb[k][i] = 16'($urandom_range(0, 65535));
            end
        load_mats();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (busy && t_cnt == 3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach_t3: got 0 expected 1");
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_a0, in_a1, in_a2, in_a3, in_b0, in_b1, in_b2, in_b3} !== '0) begin
            errors++;
            $display("FAIL abort_ops: got %h expected 0",
                     {in_a0, in_a1, in_a2, in_a3, in_b0, in_b1, in_b2, in_b3});
        end
        checks++;
        if ({arr_rst, busy, done, t_cnt} !== {3'b100, 7'd0}) begin
            errors++;
            $display("FAIL abort_ctl: got %b expected 1000000000", {arr_rst, busy, done, t_cnt});
        end
        nd = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        rst = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", nd);
        end
        do_run(-1, -1, 1'b0);
        checks++;
        if (lat !== K + 2*N + 1) begin
            errors++;
            $display("FAIL abort_rerun_latency: got %0d expected %0d", lat, K + 2*N + 1);
        end
        check_results("abort_rerun");
    endtask

    task automatic test_ignore_busy();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'(4*i + k + 3);
                mb[k][i] = 16'($urandom_range(1, 999));
            end
        load_mats();
        do_run(5, 8, 1'b0);
        checks++;
        if (lat !== K + 2*N + 1) begin
            errors++;
            $display("FAIL busy_latency: got %0d expected %0d", lat, K + 2*N + 1);
        end
        check_results("busy_run1");
        for (int n = 0; n < 3; n++) @(negedge clk);
        checks++;
        if ({busy, done, arr_rst} !== 3'b001) begin
            errors++;
            $display("FAIL busy_no_rerun: got %b expected 001", {busy, done, arr_rst});
        end
        do_run(-1, -1, 1'b0);
        check_results("busy_run2");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'($urandom_range(0, 65535));
                mb[k][i] = 16'($urandom_range(0, 65535));
            end
        load_mats();
        do_run(-1, -1, 1'b1);
        checks++;
        if (lat !== K + 2*N + 1) begin
            errors++;
            $display("FAIL b2b_latency1: got %0d expected %0d", lat, K + 2*N + 1);
        end
        check_results("b2b_run1");
        do_run(-1, -1, 1'b0);
        checks++;
        if (obs_busy[1] !== 1'b1 || obs_arr[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_clear_next: got busy=%b arr_rst=%b expected 1,1", obs_busy[1], obs_arr[1]);
        end
        checks++;
        if (lat !== K + 2*N + 1) begin
            errors++;
            $display("FAIL b2b_latency2: got %0d expected %0d", lat, K + 2*N + 1);
        end
        check_results("b2b_run2");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ones();
        test_wrap();
        test_abort();
        test_ignore_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
